// File: rtl/mem_lsu.sv
// mem_lsu: M-stage load/store unit. Issues one word-aligned bus access per
// load/store instruction, stalls the front of the pipeline until the bus
// acknowledges, and owns the M-to-W pipeline registers.
module mem_lsu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // M-stage inputs
  input  logic [31:0] i_data_aluresM,
  input  logic [31:0] i_data_writeM,
  input  logic        i_con_memwriteM,
  input  logic        i_con_memtoregM,
  input  logic        i_con_regwriteM,
  input  logic [4:0]  i_addr_writeregM,
  // memory bus
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  // pipeline control
  output logic        o_con_stall,
  // W-stage outputs
  output logic [31:0] o_data_aluresW,
  output logic [31:0] o_data_readW,
  output logic        o_con_memtoregW,
  output logic        o_con_regwriteW,
  output logic [4:0]  o_addr_writeregW
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] aluresw_q, aluresw_d;
  logic [31:0] readw_q, readw_d;
  logic        memtoregw_q, memtoregw_d;
  logic        regwritew_q, regwritew_d;
  logic [4:0]  writeregw_q, writeregw_d;

  logic access;
  logic stall;

  // A load wins over a store when both controls are set.
  assign access = i_con_memwriteM | i_con_memtoregM;

  // State register plus bus and W-stage registers; reset abandons any access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      aluresw_q   <= '0;
      readw_q     <= '0;
      memtoregw_q <= 1'b0;
      regwritew_q <= 1'b0;
      writeregw_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      aluresw_q   <= aluresw_d;
      readw_q     <= readw_d;
      memtoregw_q <= memtoregw_d;
      regwritew_q <= regwritew_d;
      writeregw_q <= writeregw_d;
    end
  end

  // Next-state, bus request and W-stage update logic.
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    readw_d     = readw_q;
    aluresw_d   = aluresw_q;
    writeregw_d = writeregw_q;
    memtoregw_d = memtoregw_q;
    regwritew_d = regwritew_q;

    case (state_q)
      IDLE: begin
        // i_mem_ack is deliberately ignored here.
        if (access) begin
          stall       = 1'b1;
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = i_con_memwriteM & ~i_con_memtoregM;
          mem_addr_d  = {i_data_aluresM[31:2], 2'b00};
          mem_wdata_d = i_data_writeM;
        end
      end
      BUSY: begin
        if (i_mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          // The registered write-enable tells us whether this was a load.
          if (!mem_we_q) readw_d = i_mem_rdata;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // While stalled W receives a bubble; otherwise the M instruction advances.
    if (stall) begin
      regwritew_d = 1'b0;
      memtoregw_d = 1'b0;
    end else begin
      aluresw_d   = i_data_aluresM;
      writeregw_d = i_addr_writeregM;
      regwritew_d = i_con_regwriteM;
      memtoregw_d = i_con_memtoregM;
    end
  end

  // Stall is combinational and forced low while reset is held.
  assign o_con_stall      = stall & i_rst_n;
  assign o_mem_req        = mem_req_q;
  assign o_mem_we         = mem_we_q;
  assign o_mem_addr       = mem_addr_q;
  assign o_mem_wdata      = mem_wdata_q;
  assign o_data_aluresW   = aluresw_q;
  assign o_data_readW     = readw_q;
  assign o_con_memtoregW  = memtoregw_q;
  assign o_con_regwriteW  = regwritew_q;
  assign o_addr_writeregW = writeregw_q;

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have i_data_aluresM, input, 32: M-stage ALU result, used as the memory address.
REQ-004 SHALL have i_data_writeM, input, 32: M-stage store data.
REQ-005 SHALL have i_con_memwriteM, i_con_memtoregM, i_con_regwriteM, inputs, 1 each: M-stage store, load and register-write controls.
REQ-006 SHALL have i_addr_writeregM, input, 5: M-stage destination register.
REQ-007 SHALL have o_mem_req, o_mem_we, outputs, 1 each: bus request and write-enable.
REQ-008 SHALL have o_mem_addr and o_mem_wdata, outputs, 32 each: bus address and write data.
REQ-009 SHALL have i_mem_ack, input, 1, and i_mem_rdata, input, 32: bus completion and read data, valid in the ack cycle.
REQ-010 SHALL have o_con_stall, output, 1: freeze F/D/E/M stages.
REQ-011 SHALL have o_data_aluresW and o_data_readW, outputs, 32 each: W-stage ALU result and load data.
REQ-012 SHALL have o_con_memtoregW and o_con_regwriteW, outputs, 1 each, and o_addr_writeregW, output, 5: W-stage controls.

Function
REQ-013 SHALL define access = i_con_memwriteM | i_con_memtoregM; a load takes precedence if both are set (o_mem_we=0).
REQ-014 SHALL implement FSM states IDLE and BUSY.
REQ-015 IDLE, access=0: SHALL stay in IDLE with o_con_stall=0; the M-to-W registers load the M-stage values (latency 1 cycle).
REQ-016 IDLE, access=1: SHALL drive o_con_stall=1 combinationally and go to BUSY.
REQ-017 On the IDLE-to-BUSY edge, SHALL register o_mem_req=1, o_mem_we=i_con_memwriteM&~i_con_memtoregM, o_mem_addr={i_data_aluresM[31:2],2'b00}, and o_mem_wdata=i_data_writeM.
REQ-018 BUSY: SHALL hold o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata stable until i_mem_ack=1.
REQ-019 BUSY, i_mem_ack=0: SHALL keep o_con_stall=1.
REQ-020 BUSY, i_mem_ack=1: SHALL drive o_con_stall=0 combinationally, and on that edge SHALL clear o_mem_req and o_mem_we and return to IDLE.
REQ-021 On the ack edge, the W registers SHALL load the M-stage values, with o_data_readW=i_mem_rdata for a load and unchanged for a store.
REQ-022 Whenever o_con_stall=1, the W registers SHALL load a bubble: o_con_regwriteW=0, o_con_memtoregW=0, other W outputs holding their values.
REQ-023 Minimum access latency SHALL be 2 cycles (IDLE cycle plus ack cycle); there is no upper bound and no timeout.
REQ-024 i_mem_ack SHALL be ignored in IDLE; i_mem_rdata SHALL be sampled only in BUSY with ack.
REQ-025 Back-to-back accesses: after the ack edge, a new access present in M SHALL start in IDLE the next cycle; the same instruction SHALL never be issued twice.
REQ-026 o_data_readW SHALL be updated only on a load-ack edge.

Reset
REQ-027 Asserting i_rst_n=0 SHALL immediately set state to IDLE and o_mem_req, o_mem_we, o_con_regwriteW and o_con_memtoregW to 0.
REQ-028 During reset, o_mem_addr, o_mem_wdata, o_data_aluresW, o_data_readW and o_addr_writeregW SHALL be 0.
REQ-029 Reset asserted mid-BUSY SHALL abandon the access with no W write; a late ack after reset release SHALL be ignored.
REQ-030 o_con_stall SHALL be 0 while in reset.

Verification
REQ-031 ALU op (aluresM=0x0000_0010, regwrite=1, reg=5), no access -> next cycle aluresW=0x10, regwriteW=1, addrW=5, stall never asserted.
REQ-032 Load from addr 0x0000_1003, ack after 3 BUSY cycles with rdata=0xDEAD_BEEF -> o_mem_addr=0x0000_1000 and req held stable 3 cycles; stall=1 for 3 cycles; readW=0xDEADBEEF, memtoregW=1 one cycle after ack; regwriteW=0 during stall.
REQ-033 Store 0x1234_5678 to 0x20, immediate ack -> req=1, we=1, wdata=0x12345678 for 1 cycle; stall=1 for 1 cycle; readW unchanged.
REQ-034 Load then store back-to-back, each acked -> exactly two bus requests in order, each separated by one IDLE cycle; no duplicate request.
REQ-035 Reset asserted in BUSY, then ack pulsed after release -> req=0 immediately, no W write, state IDLE, stall=0.
REQ-036 Spurious ack in IDLE with an ALU op in M -> no effect on the W outputs or on o_con_stall.
